// File: rtl/bcd_digit_counter_if.sv
// Interface bundle for the BCD digit counter.
// It carries the raw board inputs (pushbuttons and direction switch) and the
// registered digit outputs. Clock and reset stay as plain ports on the module.
interface bcd_digit_counter_if;
  logic [1:0] KEY;
  logic       DIR;
  logic [3:0] BCD;
  logic       CARRY;
  logic       RUN;

  // Board / testbench side: drives the buttons and switch, observes the digit
  modport master (
    output KEY,
    output DIR,
    input  BCD,
    input  CARRY,
    input  RUN
  );

  // Counter side
  modport slave (
    input  KEY,
    input  DIR,
    output BCD,
    output CARRY,
    output RUN
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit (0-9) source for the 7-segment decoder.
// Two debounced pushbuttons: KEY[0] steps the digit manually, and KEY[1]
// toggles between paused and auto-run. In auto-run the digit steps once every
// TICK_CYCLES cycles. CARRY pulses on wrap so a second instance can be chained
// as a tens digit.
module bcd_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic                MAX10_CLK1_50,
  input  logic                RST,
  bcd_digit_counter_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } mode_t;

  logic [1:0]      key_meta;
  logic [1:0]      key_sync;
  logic            dir_meta;
  logic            dir_sync;

  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      key_deb;
  logic [1:0]      key_deb_d;
  logic [1:0]      press;

  mode_t           mode_q;
  mode_t           mode_d;
  logic [TK_W-1:0] tick_cnt;
  logic            tick;
  logic            step;

  logic [3:0]      bcd_q;
  logic [3:0]      bcd_d;
  logic            carry_q;
  logic            carry_d;

  // Two-flop synchronizers for the asynchronous buttons and switch; idle high
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
      dir_meta <= 1'b1;
      dir_sync <= 1'b1;
    end else begin
      key_meta <= bus.KEY;
      key_sync <= key_meta;
      dir_meta <= bus.DIR;
      dir_sync <= dir_meta;
    end
  end

  // Per-key debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        db_cnt[k] <= '0;
      end
      key_deb <= 2'b11;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (key_sync[k] == key_deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          key_deb[k] <= key_sync[k];
          db_cnt[k]  <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // One-cycle press pulse on a debounced 1->0 edge; releases are ignored
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      key_deb_d <= 2'b11;
      press     <= 2'b00;
    end else begin
      key_deb_d <= key_deb;
      press     <= key_deb_d & ~key_deb;
    end
  end

  // Mode register: paused vs auto-run
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      mode_q <= PAUSED;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode transitions and step source selection; manual presses are dropped while running
  always_comb begin
    mode_d = mode_q;
    tick   = 1'b0;
    step   = 1'b0;
    case (mode_q)
      PAUSED: begin
        step = press[0];
        if (press[1]) begin
          mode_d = RUNNING;
        end
      end
      RUNNING: begin
        tick = (tick_cnt == TK_LAST);
        step = tick;
        if (press[1]) begin
          mode_d = PAUSED;
        end
      end
      default: begin
        mode_d = PAUSED;
      end
    endcase
  end

  // Auto-run period counter: held at zero unless running and staying running, wraps on each tick
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      tick_cnt <= '0;
    end else if (mode_q != RUNNING || mode_d != RUNNING) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TK_W'(1);
    end
  end

  // Step arithmetic with decimal wrap; an out-of-range digit recovers to 0 without carry
  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    if (step) begin
      if (bcd_q > 4'd9) begin
        bcd_d = 4'd0;
      end else if (dir_sync) begin
        if (bcd_q == 4'd9) begin
          bcd_d   = 4'd0;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_q + 4'd1;
        end
      end else begin
        if (bcd_q == 4'd0) begin
          bcd_d   = 4'd9;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_q - 4'd1;
        end
      end
    end
  end

  // Digit and carry output registers
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      bcd_q   <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign bus.BCD   = bcd_q;
  assign bus.CARRY = carry_q;
  assign bus.RUN   = (mode_q == RUNNING);

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
Upstream source stage for the single-digit BCD-to-7-segment decoder on the DE10-Lite. It debounces the two pushbuttons and holds one BCD digit (0-9). The digit steps up or down on a manual button press or on a periodic auto-run tick. Its BCD output drives the decoder's 4-bit input directly. Its CARRY pulse lets a second instance be chained as a tens digit.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive cycles a synchronized key level must differ from the debounced level before the debounced level is accepted (10 ms at 50 MHz)
TICK_CYCLES, 50000000, auto-run step period in clock cycles (1 Hz at 50 MHz)

Ports:
MAX10_CLK1_50  input  1  single system clock, 50 MHz, rising edge
RST  input  1  synchronous, active-high reset
KEY  input  2  raw pushbuttons, active low, asynchronous; KEY[0] = manual step, KEY[1] = run/pause toggle
DIR  input  1  count direction, asynchronous slide switch; 1 = up, 0 = down
BCD  output  4  current digit, always in the range 0-9, registered
CARRY  output  1  one-cycle pulse on wrap (9->0 counting up, 0->9 counting down), registered
RUN  output  1  1 = auto-run mode, 0 = paused (manual), registered

Behaviour:
- Reset (RST high at a clock edge):
  - BCD=0, CARRY=0, RUN=0.
  - Tick counter=0, debounce counters=0.
  - KEY and DIR synchronizer flops=1; debounced key levels=1 (released).
- Synchronizers: KEY[1:0] and DIR each pass through two flops before use.
- Debounce, per key:
  - The counter increments while the synced level differs from the debounced level; it clears to 0 when they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced level and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is ignored.
- Press pulse: registered one-cycle pulse on a debounced 1->0 transition. A release never produces an event.
- Latency: after a clean raw KEY[0] falling edge, BCD updates at the (DEBOUNCE_CYCLES+4)th rising edge. This is 2 sync + DEBOUNCE_CYCLES debounce + 1 pulse + 1 count register.
- Mode FSM, two states:
  - PAUSED (RUN=0) to RUNNING (RUN=1) on a KEY[1] press pulse.
  - RUNNING to PAUSED on a KEY[1] press pulse.
- Tick counter:
  - Counts only in RUNNING and is cleared on entry to RUNNING.
  - Emits a tick when it reaches TICK_CYCLES-1, then wraps to 0.
  - The first auto step therefore lands TICK_CYCLES cycles after RUN rises.
  - The counter is held at 0 while PAUSED.
- Step source:
  - PAUSED: KEY[0] press pulse.
  - RUNNING: tick only; KEY[0] presses are ignored and discarded, not queued.
- Step arithmetic, using the synced DIR:
  - Up: BCD+1, with 9->0 and CARRY=1 for that cycle.
  - Down: BCD-1, with 0->9 and CARRY=1 for that cycle.
  - CARRY is 0 on every other cycle.
  - Guard: if BCD ever holds a value above 9, the next step loads 0 regardless of direction, with no CARRY.
- Simultaneous events:
  - A tick and a KEY[1] press pulse in the same cycle: the tick step is applied and RUN toggles to 0 on the same edge.
  - KEY[0] and KEY[1] press pulses in the same cycle while PAUSED: the step is applied and RUN goes to 1.
- DIR change: takes effect on the first step after it propagates through the synchronizer. A DIR change alone never changes BCD.
- Reset mid-operation:
  - Applies at the next edge and overrides all events in that cycle.
  - A key held low across reset release is seen as a new press. It yields exactly one event, DEBOUNCE_CYCLES+4 cycles after RST falls.
- BCD only changes on a step or reset; otherwise it holds.

Test Plan:
Bench overrides DEBOUNCE_CYCLES=4 and TICK_CYCLES=10.
1. Assert RST for 3 cycles -> BCD=0, RUN=0, CARRY=0 on the first edge with RST high and held while it stays high.
2. DIR=1, ten clean KEY[0] presses (low 12 cycles, high 12 cycles) -> BCD steps 1,2,...,9,0. CARRY pulses for one cycle only on 9->0. Each update occurs 8 edges after the raw falling edge.
3. KEY[0] low 3 cycles, high 2, low 2, then low steady 12 -> exactly one increment (0->1). Release bounce of 2-cycle glitches -> no change.
4. DIR=0, BCD=0, one KEY[0] press -> BCD=9, one-cycle CARRY. A further press -> BCD=8, CARRY=0.
5. KEY[1] press -> RUN=1, then BCD increments every 10 cycles. A KEY[0] press during RUNNING -> no extra step. A second KEY[1] press -> RUN=0 and counting stops; a tick coinciding with that press is still applied.
6. RUNNING with BCD=7, RST high 1 cycle -> BCD=0, RUN=0, CARRY=0. KEY[0] held low through reset release -> exactly one increment to 1, 8 cycles after RST falls.
